alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_ctrl
//  Purpose  : Arbitrates between a fetch requester (PC increment) and an
//             execute requester (ALU op) and sequences one operation at a time
//             onto an external multi-cycle ALU. Holds the HI/LO pair written
//             by MUL/DIV, serves MFHI/MFLO/NOP/HALT locally, and flags illegal
//             op codes with a sticky error.
//
//  Ports    : Clock, Clear (async, active-high)
//             fe_req/fe_pc/fe_gnt            fetch requester
//             ex_req/ex_op/ex_a/ex_b/ex_gnt  execute requester
//             alu_control/alu_incpc/alu_a/alu_b -> ALU, alu_result <- ALU
//             done/done_fe/result/hi/lo      completion and results
//             busy/halted/err                status
//             perf_issues/perf_stalls        performance counters
//
//  Config   : define ALU_ISSUE_PERF_EN to build the performance counters;
//             otherwise perf_issues/perf_stalls are tied to zero.
//
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int MULDIV_CYCLES = 4,   // 1..15
    parameter int SIMPLE_CYCLES = 1    // 1..15
) (
    input  logic        Clock,
    input  logic        Clear,
    // fetch side
    input  logic        fe_req,
    input  logic [31:0] fe_pc,
    output logic        fe_gnt,
    // execute side
    input  logic        ex_req,
    input  logic [4:0]  ex_op,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    output logic        ex_gnt,
    // ALU side
    output logic [4:0]  alu_control,
    output logic        alu_incpc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [63:0] alu_result,
    // completion / status
    output logic        done,
    output logic        done_fe,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        halted,
    output logic        err,
    output logic [31:0] perf_issues,
    output logic [31:0] perf_stalls
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_issue = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_done  = 3'd3;
    localparam logic [2:0] c_st_halt  = 3'd4;

    localparam logic [4:0] c_op_incpc = 5'b00011;
    localparam logic [4:0] c_op_mul   = 5'b01111;
    localparam logic [4:0] c_op_div   = 5'b10000;
    localparam logic [4:0] c_op_mfhi  = 5'b11000;
    localparam logic [4:0] c_op_mflo  = 5'b11001;
    localparam logic [4:0] c_op_halt  = 5'b11011;

    localparam logic [3:0] c_muldiv_cnt = 4'(MULDIV_CYCLES);
    localparam logic [3:0] c_simple_cnt = 4'(SIMPLE_CYCLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [4:0]  r_op;        // op being served; fetch grants load c_op_incpc
    logic        r_is_fe;     // current op came from the fetch requester
    logic [3:0]  r_cnt;       // WAIT countdown
    logic        r_prio_ex;   // round-robin: 1 = execute wins a tie

    logic        r_fe_gnt;
    logic        r_ex_gnt;
    logic [4:0]  r_alu_control;
    logic        r_alu_incpc;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_done;
    logic        r_done_fe;
    logic [31:0] r_result;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_halted;
    logic        r_err;

    // ------------------------------------------------------------------
    // Arbitration and op classification
    // ------------------------------------------------------------------
    logic w_in_idle;
    logic w_grant_fe;
    logic w_grant_ex;
    logic w_ex_uses_alu;
    logic w_uses_alu;
    logic w_is_muldiv;

    assign w_in_idle  = (r_state == c_st_idle);
    // Fetch wins unless execute is also requesting and holds the priority.
    assign w_grant_fe = w_in_idle && fe_req && (!ex_req || !r_prio_ex);
    assign w_grant_ex = w_in_idle && ex_req && !w_grant_fe;

    // Op codes from MFHI upward (MFHI, MFLO, NOP, HALT, illegal) are served
    // locally and never drive the ALU.
    assign w_ex_uses_alu = (ex_op < c_op_mfhi);
    assign w_uses_alu    = (r_op < c_op_mfhi);
    // A fetch op is stored as c_op_incpc, so it can never look like MUL/DIV.
    assign w_is_muldiv   = (r_op == c_op_mul) || (r_op == c_op_div);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state       <= c_st_idle;
            r_op          <= '0;
            r_is_fe       <= 1'b0;
            r_cnt         <= '0;
            r_prio_ex     <= 1'b0;
            r_fe_gnt      <= 1'b0;
            r_ex_gnt      <= 1'b0;
            r_alu_control <= '0;
            r_alu_incpc   <= 1'b0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_done        <= 1'b0;
            r_done_fe     <= 1'b0;
            r_result      <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_halted      <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            // single-cycle pulses
            r_fe_gnt  <= 1'b0;
            r_ex_gnt  <= 1'b0;
            r_done    <= 1'b0;
            r_done_fe <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_grant_fe) begin
                        r_fe_gnt      <= 1'b1;
                        r_is_fe       <= 1'b1;
                        r_op          <= c_op_incpc;
                        r_prio_ex     <= 1'b1;
                        r_alu_incpc   <= 1'b1;
                        r_alu_control <= c_op_incpc;
                        r_alu_a       <= '0;
                        r_alu_b       <= fe_pc;
                        r_state       <= c_st_issue;
                    end else if (w_grant_ex) begin
                        r_ex_gnt  <= 1'b1;
                        r_is_fe   <= 1'b0;
                        r_op      <= ex_op;
                        r_prio_ex <= 1'b0;
                        if (ex_op > c_op_halt) begin
                            r_err <= 1'b1;
                        end
                        if (w_ex_uses_alu) begin
                            r_alu_incpc   <= 1'b0;
                            r_alu_control <= ex_op;
                            r_alu_a       <= ex_a;
                            r_alu_b       <= ex_b;
                        end
                        r_state <= c_st_issue;
                    end
                end

                c_st_issue: begin
                    if (w_uses_alu) begin
                        r_cnt   <= w_is_muldiv ? c_muldiv_cnt : c_simple_cnt;
                        r_state <= c_st_wait;
                    end else if (r_op == c_op_halt) begin
                        // HALT reports completion on entry and then parks.
                        r_done   <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= c_st_halt;
                    end else begin
                        r_state <= c_st_done;
                    end
                end

                c_st_wait: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_st_done: begin
                    r_done    <= 1'b1;
                    r_done_fe <= r_is_fe;
                    if (w_uses_alu) begin
                        r_result <= alu_result[31:0];
                        if (w_is_muldiv) begin
                            r_hi <= alu_result[63:32];
                            r_lo <= alu_result[31:0];
                        end
                    end else if (r_op == c_op_mfhi) begin
                        r_result <= r_hi;
                    end else if (r_op == c_op_mflo) begin
                        r_result <= r_lo;
                    end
                    // ALU drives are held through DONE so alu_result is
                    // still valid when sampled, then released for IDLE.
                    r_alu_incpc   <= 1'b0;
                    r_alu_control <= '0;
                    r_alu_a       <= '0;
                    r_alu_b       <= '0;
                    r_state       <= c_st_idle;
                end

                c_st_halt: begin
                    r_state <= c_st_halt;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] r_perf_issues;
    logic [31:0] r_perf_stalls;
    logic        w_granting;
    logic        w_pending;

    assign w_granting = w_grant_fe || w_grant_ex;
    assign w_pending  = fe_req || ex_req;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_perf_issues <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (w_granting) begin
                r_perf_issues <= r_perf_issues + 32'd1;
            end
            if (w_pending && !w_granting) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_issues = r_perf_issues;
    assign perf_stalls = r_perf_stalls;
`else
    assign perf_issues = '0;
    assign perf_stalls = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fe_gnt      = r_fe_gnt;
    assign ex_gnt      = r_ex_gnt;
    assign alu_control = r_alu_control;
    assign alu_incpc   = r_alu_incpc;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign done        = r_done;
    assign done_fe     = r_done_fe;
    assign result      = r_result;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign halted      = r_halted;
    assign err         = r_err;
    assign busy        = (r_state != c_st_idle) && (r_state != c_st_halt);

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_ctrl
//  Purpose  : Self-checking bench for alu_issue_ctrl. A behavioural ALU
//             answers the DUT's ALU drives; a reference model predicts each
//             completion at grant time and queues it, and an independent
//             monitor pops and compares on every done pulse.
//
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int MULDIV_CYCLES = 4;
    localparam int SIMPLE_CYCLES = 1;

    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic        fe_req = 1'b0;
    logic [31:0] fe_pc = '0;
    logic        fe_gnt;
    logic        ex_req = 1'b0;
    logic [4:0]  ex_op = '0;
    logic [31:0] ex_a = '0;
    logic [31:0] ex_b = '0;
    logic        ex_gnt;
    logic [4:0]  alu_control;
    logic        alu_incpc;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [63:0] alu_result;
    logic        done;
    logic        done_fe;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] perf_issues;
    logic [31:0] perf_stalls;

    alu_issue_ctrl #(
        .MULDIV_CYCLES(MULDIV_CYCLES),
        .SIMPLE_CYCLES(SIMPLE_CYCLES)
    ) dut (
        .Clock(Clock), .Clear(Clear),
        .fe_req(fe_req), .fe_pc(fe_pc), .fe_gnt(fe_gnt),
        .ex_req(ex_req), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b), .ex_gnt(ex_gnt),
        .alu_control(alu_control), .alu_incpc(alu_incpc), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result),
        .done(done), .done_fe(done_fe), .result(result), .hi(hi), .lo(lo),
        .busy(busy), .halted(halted), .err(err),
        .perf_issues(perf_issues), .perf_stalls(perf_stalls)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Behavioural ALU: PC increment, 64-bit MUL, DIV with {rem, quot},
    // and an arbitrary but deterministic mix for the remaining ops.
    // ------------------------------------------------------------------
    function automatic logic [63:0] alu_fn(input logic incpc, input logic [4:0] ctl,
                                           input logic [31:0] a, input logic [31:0] b);
        if (incpc) return {32'd0, b + 32'd1};
        case (ctl)
            5'd15:   return {32'd0, a} * {32'd0, b};
            5'd16:   return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: return {~(a ^ b), a + b + {27'd0, ctl}};
        endcase
    endfunction

    assign alu_result = alu_fn(alu_incpc, alu_control, alu_a, alu_b);

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic        is_fe;
        logic [31:0] result;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        logic        halted;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_result = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_err = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_favour_ex = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_result = '0; m_hi = '0; m_lo = '0;
        m_err = 1'b0; m_halted = 1'b0; m_favour_ex = 1'b0;
    endtask

    // Called at the negedge where a grant is visible; predicts the outcome.
    task automatic on_grant(input logic is_fe, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        exp_t        e;
        logic [63:0] r;
        int          lat;
        check("other_gnt_idle", is_fe ? {63'd0, ex_gnt} : {63'd0, fe_gnt}, 64'd0);
        check("busy_at_issue", {63'd0, busy}, 64'd1);
        if (is_fe) begin
            check("drv_ctl", {58'd0, alu_incpc, alu_control}, {58'd0, 1'b1, 5'b00011});
            check("drv_ab", {alu_a, alu_b}, {32'd0, pc});
            m_result = pc + 32'd1;
            lat = 2 + SIMPLE_CYCLES;
        end else begin
            if (op < 5'd24) begin
                check("drv_ctl", {58'd0, alu_incpc, alu_control}, {58'd0, 1'b0, op});
                check("drv_ab", {alu_a, alu_b}, {a, b});
            end else begin
                check("drv_ctl_local", {58'd0, alu_incpc, alu_control}, 64'd0);
                check("drv_ab_local", {alu_a, alu_b}, 64'd0);
            end
            r = alu_fn(1'b0, op, a, b);
            if (op == 5'd15 || op == 5'd16) begin
                m_hi = r[63:32]; m_lo = r[31:0]; m_result = r[31:0];
                lat = 2 + MULDIV_CYCLES;
            end else if (op < 5'd24) begin
                m_result = r[31:0];
                lat = 2 + SIMPLE_CYCLES;
            end else if (op == 5'd24) begin
                m_result = m_hi; lat = 2;
            end else if (op == 5'd25) begin
                m_result = m_lo; lat = 2;
            end else if (op == 5'd27) begin
                m_halted = 1'b1; lat = 1;
            end else begin
                if (op > 5'd27) m_err = 1'b1;
                lat = 2;
            end
        end
        m_favour_ex = is_fe;
        e.is_fe = is_fe; e.result = m_result; e.hi = m_hi; e.lo = m_lo;
        e.err = m_err; e.halted = m_halted; e.done_cyc = cyc + lat;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every done pulse against the oldest prediction.
    // ------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (done === 1'b1) begin
                check("done_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_latency", 64'(cyc), 64'(e.done_cyc));
                    check("result", {32'd0, result}, {32'd0, e.result});
                    check("hi_lo", {hi, lo}, {e.hi, e.lo});
                    check("done_fe", {63'd0, done_fe}, {63'd0, e.is_fe});
                    check("err", {63'd0, err}, {63'd0, e.err});
                    check("halted", {63'd0, halted}, {63'd0, e.halted});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers (always entered aligned to a negedge)
    // ------------------------------------------------------------------
    task automatic wait_idle(output logic [4:0] ctl_or);
        bit ok = 0;
        ctl_or = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clock);
            ctl_or = ctl_or | alu_control;
            if (sb.size() == 0) begin ok = 1; break; end
        end
        check("completion_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic drive_single(input logic is_fe, input logic [4:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, output logic [4:0] ctl_or);
        bit got = 0;
        if (is_fe) begin fe_pc = pc; fe_req = 1'b1; end
        else begin ex_op = op; ex_a = a; ex_b = b; ex_req = 1'b1; end
        for (int k = 0; k < 50; k++) begin
            @(negedge Clock);
            if ((is_fe ? fe_gnt : ex_gnt) === 1'b1) begin got = 1; break; end
        end
        fe_req = 1'b0; ex_req = 1'b0;
        check("grant_seen", {63'd0, got}, 64'd1);
        ctl_or = '0;
        if (got) begin
            on_grant(is_fe, op, a, b, pc);
            wait_idle(ctl_or);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [4:0]  ctl_or;
        logic [4:0]  op;
        int          grants;
        int          cnt;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_gnt_done", {60'd0, fe_gnt, ex_gnt, done, done_fe}, 64'd0);
        check("rst_result_hi", {result, hi}, 64'd0);
        check("rst_lo_status", {29'd0, lo, busy, halted, err}, 64'd0);
        check("rst_alu_drv", {alu_a, alu_b}, 64'd0);
        check("rst_alu_ctl", {58'd0, alu_incpc, alu_control}, 64'd0);
        check("rst_perf", {perf_issues, perf_stalls}, 64'd0);
        Clear = 1'b0;
        @(negedge Clock);

        // Fetch increment: pc 0x100 -> 0x101, done 3 cycles after grant
        drive_single(1'b1, 5'd0, 32'd0, 32'd0, 32'h100, ctl_or);

        // MUL 0x10000 * 0x10000 -> hi=1, lo=0
        drive_single(1'b0, 5'd15, 32'h10000, 32'h10000, 32'd0, ctl_or);

        // MFHI: result = hi, 2 cycles, ALU never driven
        drive_single(1'b0, 5'd24, 32'hDEAD, 32'hBEEF, 32'd0, ctl_or);
        check("mfhi_alu_ctl_zero", {59'd0, ctl_or}, 64'd0);

        // Randomized single-requester traffic (HALT excluded)
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            drive_single(1'($urandom_range(0, 1)), op, $urandom,
                         (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                         $urandom, ctl_or);
        end

        // Make hi/lo clearly non-zero, then abandon a DIV in WAIT via Clear
        drive_single(1'b0, 5'd15, 32'h12345, 32'h6789A, 32'd0, ctl_or);
        ex_op = 5'd16; ex_a = 32'h9999_0000; ex_b = 32'h77; ex_req = 1'b1;
        grants = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clock);
            if (ex_gnt === 1'b1) begin grants = 1; break; end
        end
        ex_req = 1'b0;
        check("div_grant_seen", 64'(grants), 64'd1);
        if (grants == 1) on_grant(1'b0, ex_op, ex_a, ex_b, 32'd0);
        repeat (2) @(negedge Clock);
        Clear = 1'b1;
        #1;
        sb.delete();
        model_reset();
        check("clr_busy_done", {62'd0, busy, done}, 64'd0);
        check("clr_hi_lo", {hi, lo}, 64'd0);
        check("clr_result_err", {31'd0, result, err}, 64'd0);
        @(negedge Clock);
        Clear = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (done === 1'b1) cnt++;
        end
        check("no_done_after_clear", 64'(cnt), 64'd0);

        // Both requesters held: grants alternate fe, ex, fe, ex
        fe_pc = $urandom; ex_op = 5'd0; ex_a = $urandom; ex_b = $urandom;
        fe_req = 1'b1; ex_req = 1'b1;
        grants = 0;
        for (int k = 0; k < 200 && grants < 4; k++) begin
            @(negedge Clock);
            if (fe_gnt === 1'b1 || ex_gnt === 1'b1) begin
                check("rr_order", {63'd0, fe_gnt}, {63'd0, ~m_favour_ex});
                on_grant(fe_gnt, ex_op, ex_a, ex_b, fe_pc);
                if (fe_gnt === 1'b1) fe_pc = $urandom;
                else begin ex_a = $urandom; ex_b = $urandom; end
                grants++;
            end
        end
        fe_req = 1'b0; ex_req = 1'b0;
        check("rr_grant_count", 64'(grants), 64'd4);
        wait_idle(ctl_or);
`ifdef ALU_ISSUE_PERF_EN
        check("perf_issues", {32'd0, perf_issues}, 64'd4);
`else
        check("perf_tied_zero", {perf_issues, perf_stalls}, 64'd0);
`endif

        // Illegal op -> sticky err, then HALT blocks further grants
        drive_single(1'b0, 5'd31, $urandom, $urandom, 32'd0, ctl_or);
        check("err_sticky", {63'd0, err}, 64'd1);
        drive_single(1'b0, 5'd27, 32'd0, 32'd0, 32'd0, ctl_or);
        ex_op = 5'd0; ex_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (ex_gnt === 1'b1 || fe_gnt === 1'b1) cnt++;
        end
        ex_req = 1'b0;
        check("halt_no_grant", 64'(cnt), 64'd0);
        check("halt_status", {62'd0, halted, busy}, 64'd2);

        @(negedge Clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
